switch_debounce_ctrl: RTL and testbench
=======================================

// Module: switch_debounce_ctrl
// PURPOSE
//   Memory-mapped input peripheral for NUM_SW board switches/buttons.
//   - Synchronises each raw input into clk_i and debounces it.
//   - Keeps sticky rising-edge flags and raises an interrupt level.
//   - Returns STATE / EDGE / RAW registers to the CPU bus with one-cycle read latency.
//   - Replaces the combinational switch reader on the miniRV peripheral bus.
// PARAMETERS
//   NUM_SW        24     number of switch channels, 1..32
//   TICK_DIV      10000  clk_i cycles per debounce sample tick, >= 2
//   STABLE_N      4      consecutive equal samples needed to accept a new level, 1..15
// PORTS
//   clk_i         in   1          system clock
//   rst_i         in   1          synchronous reset, active-high
//   sw_i          in   NUM_SW     raw asynchronous switch levels
//   sw_adr_i      in   32         byte address; only bits [3:2] are decoded
//   sw_re_i       in   1          read strobe
//   sw_we_i       in   1          write strobe
//   sw_wd_i       in   32         write data
//   sw_rd_o       out  32         read data, valid the cycle after sw_re_i
//   sw_irq_o      out  1          high while any enabled EDGE bit is set
// BEHAVIOUR
//   Reset (rst_i high at a clk_i edge):
//   - Clears synchronisers, tick counter, per-channel counters, STATE, EDGE, IEN.
//   - Drives sw_rd_o = 0 and sw_irq_o = 0.
//   - Reset mid-debounce discards any partial count.
//   Sync: 2 flops per bit, giving RAW. RAW is 2 cycles behind sw_i.
//   Tick: a counter runs 0..TICK_DIV-1 and wraps to 0.
//   - tick = 1 for one cycle when the counter equals TICK_DIV-1.
//   Per channel, evaluated on a tick cycle only:
//   - RAW == STATE: clear the counter.
//   - RAW != STATE: increment the counter. On reaching STABLE_N, STATE <= RAW and the counter clears.
//   - A glitch shorter than STABLE_N ticks never changes STATE.
//   Edge detect: when STATE goes 0->1, set EDGE[i] in the same cycle STATE updates.
//   Register map (sw_adr_i[3:2]):
//   - 0 STATE    RO  {zero-pad, STATE}
//   - 1 EDGE     W1C  write 1 clears the bit
//   - 2 RAW      RO  synchronised levels
//   - 3 IEN      RW  interrupt enable mask, bits above NUM_SW read 0
//   Read: sw_rd_o is registered on a cycle with sw_re_i = 1.
//   - The value holds until the next read; sw_re_i = 0 keeps the previous value.
//   Write: takes effect at the clk_i edge where sw_we_i = 1. Writes to RO registers are ignored.
//   Simultaneous events:
//   - Set and W1C clear of the same EDGE bit in one cycle: the set wins and the bit stays 1.
//   - Read and write of the same register in one cycle: the read returns the pre-write value.
//   sw_irq_o = |(EDGE & IEN), registered with 1-cycle latency.
//   Upper bits [31:NUM_SW] of every register read 0.
// STRUCTURE
//   Shared package (sw_pkg):
//   - Register offsets SW_REG_STATE=2'd0, SW_REG_EDGE=2'd1, SW_REG_RAW=2'd2, SW_REG_IEN=2'd3.
//   - SW_DATA_W=32.
//   Sub-module sw_debounce_bit:
//   - One channel: STATE flop plus a 4-bit counter, driven by tick and RAW bit.
//   - Instantiated NUM_SW times via generate.
//   The top level holds the synchroniser, tick counter, EDGE/IEN registers and bus decode.
// TESTING  (NUM_SW=8, TICK_DIV=4, STABLE_N=3)
//   1. Reset, then read 0,1,2,3 -> all return 0; sw_irq_o = 0.
//   2. Hold sw_i=8'hA5 for 16 cycles.
//      -> RAW reads A5 after 2 cycles; STATE reads A5 only after the 3rd tick.
//      -> EDGE reads A5.
//   3. Toggle sw_i[0] for 2 ticks, then return it.
//      -> STATE[0] never changes; EDGE[0] stays 0.
//   4. IEN=8'h01; raise sw_i[0] stably.
//      -> sw_irq_o goes to 1 one cycle after EDGE[0] sets.
//      -> write EDGE=8'h01; sw_irq_o goes to 0 next cycle.
//   5. Force a W1C of EDGE[1] on the same cycle STATE[1] rises -> EDGE[1] reads 1.
//   6. Assert rst_i mid-count with sw_i changed.
//      -> STATE = 0 after reset.
//      -> a full STABLE_N ticks are required again before STATE updates.

Source files
------------

// File: rtl/sw_pkg.sv
// sw_pkg: shared register offsets and bus width for the switch debounce peripheral
package sw_pkg;
  localparam int SW_DATA_W = 32;
  localparam logic [1:0] SW_REG_STATE = 2'd0;
  localparam logic [1:0] SW_REG_EDGE = 2'd1;
  localparam logic [1:0] SW_REG_RAW = 2'd2;
  localparam logic [1:0] SW_REG_IEN = 2'd3;
endpackage

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: one channel, accepts a new level after STABLE_N consecutive differing ticks
module sw_debounce_bit #(
  parameter int STABLE_N = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick,
  input  logic raw,
  output logic state,
  output logic rise
);
  logic [3:0] cnt;
  logic done;
  assign done = tick && raw != state && cnt == 4'(STABLE_N - 1);
  assign rise = done && raw;
  // count ticks on which raw disagrees with state; any agreeing tick restarts the run
  always_ff @(posedge clk_i)
    if (rst_i) begin
      cnt <= 4'd0;
      state <= 1'b0;
    end else if (tick) begin
      cnt <= (raw == state || done) ? 4'd0 : cnt + 4'd1;
      state <= done ? raw : state;
    end
endmodule

// File: rtl/switch_debounce_ctrl.sv
// switch_debounce_ctrl: synchronised, debounced switch inputs with sticky edge flags and IRQ on the CPU bus
module switch_debounce_ctrl
  import sw_pkg::*;
#(
  parameter int NUM_SW = 24,
  parameter int TICK_DIV = 10000,
  parameter int STABLE_N = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_SW-1:0]    sw_i,
  input  logic [31:0]          sw_adr_i,
  input  logic                 sw_re_i,
  input  logic                 sw_we_i,
  input  logic [31:0]          sw_wd_i,
  output logic [SW_DATA_W-1:0] sw_rd_o,
  output logic                 sw_irq_o
);
  localparam int TW = $clog2(TICK_DIV);
  logic [NUM_SW-1:0] sync1, raw, state, rise, edges, ien;
  logic [TW-1:0] tcnt;
  logic tick, wr_edge, wr_ien;
  logic [1:0] sel;
  logic [SW_DATA_W-1:0] rdata;
  logic unused_bits;
  assign unused_bits = ^{sw_adr_i[31:4], sw_adr_i[1:0], sw_wd_i};
  assign sel = sw_adr_i[3:2];
  assign tick = tcnt == TW'(TICK_DIV - 1);
  assign wr_edge = sw_we_i && sel == SW_REG_EDGE;
  assign wr_ien = sw_we_i && sel == SW_REG_IEN;
  // two-flop synchroniser and free-running sample tick divider
  always_ff @(posedge clk_i)
    if (rst_i) begin
      sync1 <= '0;
      raw <= '0;
      tcnt <= '0;
    end else begin
      sync1 <= sw_i;
      raw <= sync1;
      tcnt <= tick ? '0 : tcnt + TW'(1);
    end
  for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
    sw_debounce_bit #(.STABLE_N(STABLE_N)) u_bit (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .tick(tick),
      .raw(raw[i]),
      .state(state[i]),
      .rise(rise[i])
    );
  end
  // sticky edges: a new rise overrides a same-cycle W1C clear
  always_ff @(posedge clk_i)
    if (rst_i) begin
      edges <= '0;
      ien <= '0;
    end else begin
      edges <= (edges & ~(wr_edge ? sw_wd_i[NUM_SW-1:0] : '0)) | rise;
      ien <= wr_ien ? sw_wd_i[NUM_SW-1:0] : ien;
    end
  // read mux over the pre-write register values, zero-padded to the bus width
  always_comb
    rdata = sel == SW_REG_STATE ? SW_DATA_W'(state) :
            sel == SW_REG_EDGE  ? SW_DATA_W'(edges) :
            sel == SW_REG_RAW   ? SW_DATA_W'(raw) : SW_DATA_W'(ien);
  // registered read data (held between reads) and interrupt level
  always_ff @(posedge clk_i)
    if (rst_i) begin
      sw_rd_o <= '0;
      sw_irq_o <= 1'b0;
    end else begin
      sw_rd_o <= sw_re_i ? rdata : sw_rd_o;
      sw_irq_o <= |(edges & ien);
    end
endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// tb_switch_debounce_ctrl: directed checks of sync, debounce, edges, IRQ and bus behaviour
module tb_switch_debounce_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] sw = '0;
  logic [31:0] adr = '0;
  logic re = 1'b0;
  logic we = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] rd_o;
  logic irq;
  int checks = 0;
  int errors = 0;

  switch_debounce_ctrl #(.NUM_SW(8), .TICK_DIV(4), .STABLE_N(3)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .sw_i(sw),
    .sw_adr_i(adr),
    .sw_re_i(re),
    .sw_we_i(we),
    .sw_wd_i(wd),
    .sw_rd_o(rd_o),
    .sw_irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    re = 1'b0;
    we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    adr = a;
    re = 1'b1;
    @(negedge clk);
    d = rd_o;
    re = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    adr = a;
    wd = v;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rw(input logic [31:0] a, input logic [31:0] v, output logic [31:0] d);
    adr = a;
    wd = v;
    we = 1'b1;
    re = 1'b1;
    @(negedge clk);
    d = rd_o;
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_dut();
    sw = 8'h00;
    checks++; if (rd_o !== 32'h0) begin errors++; $display("FAIL reset_rd got %h want %h", rd_o, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    for (int i = 0; i < 4; i++) begin
      rd(32'(i * 4), d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got %h want %h", i, d, 32'h0); end
    end
  endtask

  task automatic test_stable();
    logic [31:0] d;
    reset_dut();
    sw = 8'hA5;
    rd(32'h8, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL raw_c0 got %h want %h", d, 32'h0); end
    rd(32'h8, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL raw_c1 got %h want %h", d, 32'h0); end
    rd(32'h8, d);
    checks++; if (d !== 32'hA5) begin errors++; $display("FAIL raw_c2 got %h want %h", d, 32'hA5); end
    cyc(7);
    rd(32'h0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL state_before_tick3 got %h want %h", d, 32'h0); end
    rd(32'h0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL state_at_tick3 got %h want %h", d, 32'h0); end
    rd(32'h0, d);
    checks++; if (d !== 32'hA5) begin errors++; $display("FAIL state_after_tick3 got %h want %h", d, 32'hA5); end
    rd(32'h4, d);
    checks++; if (d !== 32'hA5) begin errors++; $display("FAIL edge_a5 got %h want %h", d, 32'hA5); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked got %b want 0", irq); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    reset_dut();
    sw = 8'h01;
    cyc(8);
    sw = 8'h00;
    rd(32'h0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL glitch_state_mid got %h want %h", d, 32'h0); end
    cyc(3);
    rd(32'h0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL glitch_state got %h want %h", d, 32'h0); end
    rd(32'h4, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL glitch_edge got %h want %h", d, 32'h0); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    reset_dut();
    sw = 8'h01;
    wr(32'hC, 32'h01);
    rd(32'hC, d);
    checks++; if (d !== 32'h01) begin errors++; $display("FAIL ien_read got %h want %h", d, 32'h01); end
    cyc(10);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_at_edge got %b want 0", irq); end
    cyc(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b want 1", irq); end
    wr(32'h4, 32'h01);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_at_clear got %b want 1", irq); end
    cyc(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got %b want 0", irq); end
  endtask

  task automatic test_collide();
    logic [31:0] d;
    reset_dut();
    sw = 8'h02;
    rw(32'hC, 32'hFFFF_FFFF, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rw_prewrite got %h want %h", d, 32'h0); end
    rd(32'hC, d);
    checks++; if (d !== 32'h0000_00FF) begin errors++; $display("FAIL ien_pad got %h want %h", d, 32'h0000_00FF); end
    wr(32'h0, 32'hFF);
    cyc(8);
    wr(32'h4, 32'h02);
    rd(32'h4, d);
    checks++; if (d !== 32'h02) begin errors++; $display("FAIL set_beats_clear got %h want %h", d, 32'h02); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL collide_irq got %b want 1", irq); end
    rd(32'h0, d);
    checks++; if (d !== 32'h02) begin errors++; $display("FAIL state_ro got %h want %h", d, 32'h02); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    reset_dut();
    sw = 8'h01;
    cyc(8);
    reset_dut();
    checks++; if (rd_o !== 32'h0) begin errors++; $display("FAIL mid_rd_clr got %h want %h", rd_o, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq got %b want 0", irq); end
    rd(32'h0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_state0 got %h want %h", d, 32'h0); end
    cyc(9);
    rd(32'h0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_state_t2 got %h want %h", d, 32'h0); end
    rd(32'h0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_state_t3 got %h want %h", d, 32'h0); end
    rd(32'h0, d);
    checks++; if (d !== 32'h01) begin errors++; $display("FAIL mid_state_done got %h want %h", d, 32'h01); end
  endtask

  initial begin
    test_reset();
    test_stable();
    test_glitch();
    test_irq();
    test_collide();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
